// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
//   in_valid/in_data/in_ready : 8-bit valid/ready program-image stream
//   wr_en/wr_addr/wr_data     : one-cycle word write strobe into instruction memory
// master = image source / memory side, slave = loader.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader. Receives a framed image
// (N lo, N hi, 4*N little-endian data bytes, checksum byte), writes each
// assembled word to instruction memory and releases the core reset only
// after a complete image with a correct checksum.
//   clk, rst    : clock, asynchronous active-low reset
//   start       : one-cycle session request (honoured in IDLE/DONE/ERR)
//   bus         : byte stream in, word write port out
//   core_rst    : active-low core reset, 1 only in DONE
//   busy/done/error : status (LEN..CSUM / DONE / ERR)
//   word_count  : words written in the current session
module imem_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam logic [16:0] MAX_WORDS = 17'(1 << ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t             r_state,      w_state;
  logic [1:0]         r_byte_idx,   w_byte_idx;
  logic [15:0]        r_len,        w_len;
  logic [23:0]        r_word,       w_word;
  logic [7:0]         r_sum,        w_sum;
  logic [CNT_W-1:0]   r_word_count, w_word_count;
  logic               r_wr_en,      w_wr_en;
  logic [31:0]        r_wr_addr,    w_wr_addr;
  logic [31:0]        r_wr_data,    w_wr_data;
  logic               r_in_ready,   w_in_ready;
  logic               r_busy,       w_busy;
  logic               r_done,       w_done;
  logic               r_error,      w_error;
  logic               r_core_rst,   w_core_rst;

  logic               w_xfer;
  logic [15:0]        w_new_len;
  logic [7:0]         w_sum_add;
  logic               w_last_word;

  // r_in_ready mirrors "state is LEN/DATA/CSUM", so it gates acceptance directly
  assign w_xfer      = bus.in_valid && r_in_ready;
  assign w_new_len   = {bus.in_data, r_len[7:0]};
  assign w_sum_add   = r_sum + bus.in_data;
  assign w_last_word = (17'(r_word_count) + 17'd1) == {1'b0, r_len};

  // Next-state and next-register computation
  always_comb begin
    w_state      = r_state;
    w_byte_idx   = r_byte_idx;
    w_len        = r_len;
    w_word       = r_word;
    w_sum        = r_sum;
    w_word_count = r_word_count;
    w_wr_en      = 1'b0;
    w_wr_addr    = r_wr_addr;
    w_wr_data    = r_wr_data;

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          w_state      = S_LEN;
          w_byte_idx   = 2'd0;
          w_sum        = 8'd0;
          w_word_count = '0;
        end
      end

      S_LEN: begin
        if (w_xfer) begin
          if (r_byte_idx == 2'd0) begin
            w_len[7:0] = bus.in_data;
            w_byte_idx = 2'd1;
          end else begin
            w_len      = w_new_len;
            w_byte_idx = 2'd0;
            if (w_new_len == 16'd0 || {1'b0, w_new_len} > MAX_WORDS) begin
              w_state = S_ERR;
            end else begin
              w_state = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (w_xfer) begin
          w_sum      = w_sum_add;
          w_byte_idx = 2'(r_byte_idx + 2'd1);
          case (r_byte_idx)
            2'd0: w_word[7:0]   = bus.in_data;
            2'd1: w_word[15:8]  = bus.in_data;
            2'd2: w_word[23:16] = bus.in_data;
            default: begin
              // Fourth byte completes the word; address wraps in 32 bits
              w_wr_en      = 1'b1;
              w_wr_addr    = BASE_ADDR + (32'(r_word_count) << 2);
              w_wr_data    = {bus.in_data, r_word};
              w_word_count = r_word_count + CNT_W'(1);
              if (w_last_word) begin
                w_state = S_CSUM;
              end
            end
          endcase
        end
      end

      S_CSUM: begin
        if (w_xfer) begin
          w_sum   = w_sum_add;
          w_state = (w_sum_add == 8'd0) ? S_DONE : S_ERR;
        end
      end

      default: w_state = S_IDLE;
    endcase

    // Status outputs are registered decodes of the upcoming state
    w_in_ready = (w_state == S_LEN) || (w_state == S_DATA) || (w_state == S_CSUM);
    w_busy     = w_in_ready;
    w_done     = (w_state == S_DONE);
    w_core_rst = (w_state == S_DONE);
    w_error    = (w_state == S_ERR);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_byte_idx   <= 2'd0;
      r_len        <= 16'd0;
      r_word       <= 24'd0;
      r_sum        <= 8'd0;
      r_word_count <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= 32'd0;
      r_wr_data    <= 32'd0;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_core_rst   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_byte_idx   <= w_byte_idx;
      r_len        <= w_len;
      r_word       <= w_word;
      r_sum        <= w_sum;
      r_word_count <= w_word_count;
      r_wr_en      <= w_wr_en;
      r_wr_addr    <= w_wr_addr;
      r_wr_data    <= w_wr_data;
      r_in_ready   <= w_in_ready;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_error      <= w_error;
      r_core_rst   <= w_core_rst;
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign core_rst     = r_core_rst;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign word_count   = r_word_count;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader for the single-cycle RISC-V core. It accepts a framed program image over an 8-bit valid/ready byte stream and assembles little-endian 32-bit words. Each word is written through the instruction memory's write port. The core's reset stays asserted until a complete image with a correct checksum has been written.

## Interface
Parameters:
- ADDR_W, 8: word-address width of the instruction memory; capacity is 2^ADDR_W words.
- BASE_ADDR, 32'h0000_0000: byte address of the first word written.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load session; honoured only in IDLE, DONE, ERR.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte-stream ready; a function of state only.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  32  byte address of the write; BASE_ADDR + 4*word index.
- wr_data  out  32  assembled word.
- core_rst  out  1  active-low reset to the core; 1 only in DONE.
- busy  out  1  high in LEN, DATA, CSUM.
- done  out  1  high in DONE.
- error  out  1  high in ERR.
- word_count  out  ADDR_W+1  number of words written in the current session.

## Operation
- A byte transfers on a rising edge with in_valid && in_ready. in_ready is 1 in LEN, DATA, CSUM and 0 otherwise. It never depends on in_valid.
- Frame: 2 length bytes giving N (16-bit word count, LSB first), then 4*N data bytes (each word LSB first), then 1 checksum byte C.
- The frame is valid iff (sum of all 4*N data bytes + C) mod 256 == 0.
- States:
  - IDLE: start → LEN. Clears word_count, the byte index, and the 8-bit running sum.
  - LEN: after the 2nd length byte, N==0 or N>2^ADDR_W → ERR; else → DATA.
  - DATA: shifts each accepted byte into the word register at its byte position and adds it to the running sum. When the 4th byte of word k is accepted, the block registers wr_en=1, wr_addr=BASE_ADDR+4k, wr_data=word, and increments word_count. After word N-1 → CSUM.
  - CSUM: on acceptance of C, → DONE if (sum+C)[7:0]==0, else → ERR.
  - DONE: core_rst=1. start → LEN, and core_rst returns to 0.
  - ERR: holds. start → LEN.
- start is ignored in LEN, DATA, CSUM.
- Words already written are never undone, whether the session errors or is reset.
- Arithmetic:
  - The sum wraps mod 256.
  - The word index spans 0..2^ADDR_W-1.
  - wr_addr is computed in 32 bits and wraps mod 2^32.

## Timing
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, core_rst=0, busy=0, done=0, error=0, word_count=0, state IDLE.
- rst low at any time, including mid-session, forces all of the above immediately, without waiting for a clock edge.
- Session start: start sampled high in edge T → state LEN and in_ready=1 from T+1.
- Write latency: wr_en is high for exactly the cycle after the 4th byte of a word is accepted. The last word's wr_en coincides with the first cycle of CSUM.
- Completion: done/core_rst (or error) rise the cycle after C is accepted.
- Throughput: one byte per cycle sustained. A gap-free frame of N words completes 4N+3 cycles after the first accepted byte.
- in_data changes while in_valid=0 or in_ready=0 have no effect.

## Test plan
- Good load:
  - Stimulus: reset, start, then bytes 02 00 | 93 00 50 00 | 13 01 A0 00 | 69, gap-free.
  - Required response: wr_en pulses at addr 0x0 with data 0x00500093 and at addr 0x4 with data 0x00A00113. Next, word_count=2 and done=1. core_rst=1 the cycle after 0x69 is accepted.
- Bad checksum:
  - Stimulus: the same frame with C=0x68.
  - Required response: both writes occur, then error=1, done=0, core_rst=0, in_ready=0. A new start with the correct frame reaches DONE.
- Length bounds:
  - Stimulus 1: N=0 (bytes 00 00). Required response: ERR after the 2nd byte, no wr_en.
  - Stimulus 2: with ADDR_W=8, N=257 (01 01). Required response: ERR.
  - Stimulus 3: with ADDR_W=8, N=256. Required response: accepted, last write at addr 0x3FC.
- Backpressure and gaps:
  - Stimulus: the good-load frame with in_valid low on alternating cycles and garbage on in_data while in_valid is low.
  - Required response: writes, data, and final state identical to the good-load scenario.
- Reset mid-session:
  - Stimulus: rst low after 5 accepted bytes.
  - Required response: all outputs take their reset values immediately. After release, start plus the good frame → done=1.
- Ignored start:
  - Stimulus: start pulses during LEN, DATA, and CSUM.
  - Required response: no change in state, word_count, or sum. The good frame still completes.
